modport_sync_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO that exposes the `winc`/`wdata`/`wfull` write port and the `rinc`/`rdata`/`rempty` read port used by the FIFO drivers and monitors. It buffers `2**ASIZE` words of `DSIZE` bits between a producer and a consumer that share one clock domain. Occupancy and error pulses are provided for scoreboarding.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_mem.sv | 19 +
 rtl/modport_sync_fifo.sv | 48 ++++
 tb/tb_modport_sync_fifo.sv | 96 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO geometry defaults and pointer type
package fifo_pkg;
  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;
  typedef logic [DEF_ASIZE:0] ptr_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2**ASIZE x DSIZE RAM, synchronous write, asynchronous read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [2**ASIZE];
  always_ff @(posedge clk)
    if (wclken) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/modport_sync_fifo.sv
// modport_sync_fifo: single-clock first-word-fall-through FIFO with occupancy and error pulses
module modport_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  logic [ASIZE:0] wptr, rptr;
  logic wen, ren;
  // MSB is the lap bit: equal low bits with differing laps means full
  assign rempty = wptr == rptr;
  assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign count  = wptr - rptr;
  assign wen    = winc && !wfull;
  assign ren    = rinc && !rempty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + {{ASIZE{1'b0}}, wen};
      rptr      <= rptr + {{ASIZE{1'b0}}, ren};
      overflow  <= winc && wfull;
      underflow <= rinc && rempty;
    end
  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk    (clk),
    .wclken (wen),
    .waddr  (wptr[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr[ASIZE-1:0]),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_modport_sync_fifo.sv
// tb_modport_sync_fifo: directed plus randomized checks against a queue model
module tb_modport_sync_fifo;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 0, winc = 0, rinc = 0;
  logic [7:0] wdata = '0;
  logic wfull, rempty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic exp_ovf = 0, exp_unf = 0;
  modport_sync_fifo dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ":rempty"}, 32'(rempty), 32'(q.size() == 0));
    chk({tag, ":wfull"}, 32'(wfull), 32'(q.size() == DEPTH));
    chk({tag, ":count"}, 32'(count), q.size());
    chk({tag, ":overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(exp_unf));
    if (q.size() != 0) chk({tag, ":rdata"}, 32'(rdata), 32'(q[0]));
  endtask
  // model evaluates acceptance on pre-edge occupancy, then applies pop and push
  task automatic step(string tag, logic w, logic r, logic [7:0] d);
    bit aw, ar;
    winc = w; rinc = r; wdata = d;
    @(posedge clk);
    aw = w && q.size() < DEPTH;
    ar = r && q.size() != 0;
    exp_ovf = w && !aw;
    exp_unf = r && q.size() == 0;
    if (ar) void'(q.pop_front());
    if (aw) q.push_back(d);
    #1;
    winc = 0; rinc = 0;
    check_all(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1;
    step("idle", 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) step("fill", 1, 0, 8'(i));
    chk("full16", 32'(wfull), 1);
    chk("count16", 32'(count), 16);
    step("ovf", 1, 0, 8'hAA);
    chk("ovf_pulse", 32'(overflow), 1);
    step("ovf_clear", 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 32'(rdata), i);
      step("drain", 0, 1, 8'h00);
    end
    step("unf", 0, 1, 8'h00);
    chk("unf_pulse", 32'(underflow), 1);
    step("unf_clear", 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step("fill8", 1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) step("both", 1, 1, 8'(8'h40 + i));
    chk("both_count", 32'(count), 8);
    while (q.size() < DEPTH) step("refill", 1, 0, 8'($urandom));
    step("full_both", 1, 1, 8'hEE);
    chk("full_both_count", 32'(count), 15);
    chk("full_both_ovf", 32'(overflow), 1);
    while (q.size() != 0) step("empty_out", 0, 1, 8'h00);
    step("empty_both", 1, 1, 8'h77);
    chk("empty_both_unf", 32'(underflow), 1);
    step("pop77", 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 8'(8'h60 + i));
    #3 rst = 0;
    #1;
    q.delete();
    exp_ovf = 0; exp_unf = 0;
    check_all("async_rst");
    @(negedge clk) rst = 1;
    step("w55", 1, 0, 8'h55);
    chk("rd55", 32'(rdata), 32'h55);
    step("r55", 0, 1, 8'h00);
    for (int p = 0; p < 4; p++) begin
      int wp;
      wp = (p == 0) ? 75 : (p == 1) ? 25 : 50;
      repeat (150)
        step("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
